// File: rtl/ping_pong_pkg.sv
// Shared types and default geometry for the QnxKnT ping-pong buffer path.
package ping_pong_pkg;

    localparam int unsigned PP_INNER_BLK  = 4;
    localparam int unsigned PP_ROW_TILES  = 2;
    localparam int unsigned PP_COL_TILES  = 2;
    localparam int unsigned MAX_FLAG_PP   = PP_ROW_TILES * PP_COL_TILES;
    localparam int unsigned PP_SEQ_BEATS  = MAX_FLAG_PP * PP_INNER_BLK;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        STREAM,
        DRAIN,
        RELEASE
    } pp_seq_state_t;

    // Counter width for a modulus n; never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pp_tile_addr_gen.sv
// Nested k (fastest) / c / r tile counters with wrap and last-element flags.
module pp_tile_addr_gen
    import ping_pong_pkg::*;
#(
    parameter int unsigned INNER_BLK = PP_INNER_BLK,
    parameter int unsigned ROW_TILES = PP_ROW_TILES,
    parameter int unsigned COL_TILES = PP_COL_TILES,
    parameter int unsigned K_W       = cnt_w(INNER_BLK),
    parameter int unsigned C_W       = cnt_w(COL_TILES),
    parameter int unsigned R_W       = cnt_w(ROW_TILES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           step,
    input  logic           clear,
    output logic [K_W-1:0] k,
    output logic [C_W-1:0] c,
    output logic [R_W-1:0] r,
    output logic           k_last_c,
    output logic           c_last_c,
    output logic           r_last_c
);

    assign k_last_c = (k == K_W'(INNER_BLK - 1));
    assign c_last_c = (c == C_W'(COL_TILES - 1));
    assign r_last_c = (r == R_W'(ROW_TILES - 1));

    // Advance k each step; carry into c, then r, each wrapping at its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
            c <= '0;
            r <= '0;
        end else if (clear) begin
            k <= '0;
            c <= '0;
            r <= '0;
        end else if (step) begin
            if (k_last_c) begin
                k <= '0;
                if (c_last_c) begin
                    c <= '0;
                    r <= r_last_c ? '0 : r + R_W'(1);
                end else begin
                    c <= c + C_W'(1);
                end
            end else begin
                k <= k + K_W'(1);
            end
        end
    end

endmodule

// File: rtl/pp_qk_read_sequencer.sv
// Reads paired West/North words from the ready ping-pong bank and streams them
// tile by tile into the QnxKnT matmul, then releases the bank and swaps.
// Optional build macro: PP_SEQ_PERF_EN adds saturating busy/stall counters.
module pp_qk_read_sequencer
    import ping_pong_pkg::*;
#(
    parameter int unsigned INNER_BLK = PP_INNER_BLK,
    parameter int unsigned ROW_TILES = PP_ROW_TILES,
    parameter int unsigned COL_TILES = PP_COL_TILES,
    parameter int unsigned W_WIDTH   = 256,
    parameter int unsigned N_WIDTH   = 256,
    parameter int unsigned ADDR_W_W  = $clog2(ROW_TILES * INNER_BLK),
    parameter int unsigned ADDR_W_N  = $clog2(COL_TILES * INNER_BLK)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          w_bank_full,
    input  logic [1:0]          n_bank_full,
    output logic [1:0]          bank_release,
    output logic                rd_bank,
    output logic                w_rd_en,
    output logic [ADDR_W_W-1:0] w_rd_addr,
    output logic                n_rd_en,
    output logic [ADDR_W_N-1:0] n_rd_addr,
    input  logic [W_WIDTH-1:0]  w_rd_data,
    input  logic [N_WIDTH-1:0]  n_rd_data,
    input  logic                mm_ready,
    output logic                mm_valid,
    output logic [W_WIDTH-1:0]  mm_w_data,
    output logic [N_WIDTH-1:0]  mm_n_data,
    output logic                mm_first,
    output logic                mm_last,
    output logic                seq_done
`ifdef PP_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_busy_cyc,
    output logic [31:0]         perf_stall_cyc
`endif
);

    localparam int unsigned K_W = cnt_w(INNER_BLK);
    localparam int unsigned C_W = cnt_w(COL_TILES);
    localparam int unsigned R_W = cnt_w(ROW_TILES);

    pp_seq_state_t  state;
    logic [K_W-1:0] k;
    logic [C_W-1:0] c;
    logic [R_W-1:0] r;
    logic           k_last_c;
    logic           c_last_c;
    logic           r_last_c;
    logic           advance_c;
    logic           issue_c;
    logic           last_issue_c;

    // A read may go out only when the output slot is empty or draining this cycle.
    assign advance_c    = ~mm_valid | mm_ready;
    assign issue_c      = (state == STREAM) & advance_c;
    assign last_issue_c = issue_c & k_last_c & c_last_c & r_last_c;

    assign w_rd_en   = issue_c;
    assign n_rd_en   = issue_c;
    assign w_rd_addr = ADDR_W_W'(32'(r) * INNER_BLK + 32'(k));
    assign n_rd_addr = ADDR_W_N'(32'(c) * INNER_BLK + 32'(k));

    // Read data arrives one cycle after issue and is held by the buffer while en is low.
    assign mm_w_data = mm_valid ? w_rd_data : '0;
    assign mm_n_data = mm_valid ? n_rd_data : '0;

    pp_tile_addr_gen #(
        .INNER_BLK (INNER_BLK),
        .ROW_TILES (ROW_TILES),
        .COL_TILES (COL_TILES),
        .K_W       (K_W),
        .C_W       (C_W),
        .R_W       (R_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (issue_c),
        .clear    (state == RELEASE),
        .k        (k),
        .c        (c),
        .r        (r),
        .k_last_c (k_last_c),
        .c_last_c (c_last_c),
        .r_last_c (r_last_c)
    );

    // Bank sequencing FSM plus the registered beat-valid/marker stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_bank      <= 1'b0;
            mm_valid     <= 1'b0;
            mm_first     <= 1'b0;
            mm_last      <= 1'b0;
            bank_release <= '0;
            seq_done     <= 1'b0;
        end else begin
            bank_release <= '0;
            seq_done     <= 1'b0;

            if (issue_c) begin
                mm_valid <= 1'b1;
                mm_first <= (k == '0);
                mm_last  <= k_last_c;
            end else if (mm_ready) begin
                mm_valid <= 1'b0;
                mm_first <= 1'b0;
                mm_last  <= 1'b0;
            end

            case (state)
                IDLE:      state <= WAIT_BANK;
                WAIT_BANK: if (w_bank_full[rd_bank] & n_bank_full[rd_bank]) state <= STREAM;
                STREAM:    if (last_issue_c) state <= DRAIN;
                DRAIN: begin
                    if (mm_valid & mm_ready) begin
                        state                 <= RELEASE;
                        bank_release[rd_bank] <= 1'b1;
                        seq_done              <= 1'b1;
                    end
                end
                RELEASE: begin
                    rd_bank <= ~rd_bank;
                    state   <= WAIT_BANK;
                end
                default:   state <= IDLE;
            endcase
        end
    end

    // The writer must not withdraw the bank while it is being streamed.
    full_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state == STREAM) |-> (w_bank_full[rd_bank] & n_bank_full[rd_bank]));

`ifdef PP_SEQ_PERF_EN
    // Saturating activity and backpressure counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if ((state != IDLE) && (state != WAIT_BANK) && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (mm_valid && !mm_ready && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pp_qk_read_sequencer.sv
// Scoreboard bench for pp_qk_read_sequencer with a 2x2 tile, 2-beat inner config.
module tb_pp_qk_read_sequencer;

    localparam int unsigned IB = 2;
    localparam int unsigned RT = 2;
    localparam int unsigned CT = 2;
    localparam int unsigned WW = 32;
    localparam int unsigned NW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned AN = 2;

    typedef struct packed {
        logic [WW-1:0] w;
        logic [NW-1:0] n;
        logic          first;
        logic          last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [1:0]    w_bank_full;
    logic [1:0]    n_bank_full;
    logic [1:0]    bank_release;
    logic          rd_bank;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          n_rd_en;
    logic [AN-1:0] n_rd_addr;
    logic [WW-1:0] w_rd_data;
    logic [NW-1:0] n_rd_data;
    logic          mm_ready;
    logic          mm_valid;
    logic [WW-1:0] mm_w_data;
    logic [NW-1:0] mm_n_data;
    logic          mm_first;
    logic          mm_last;
    logic          seq_done;
`ifdef PP_SEQ_PERF_EN
    logic [31:0]   perf_busy_cyc;
    logic [31:0]   perf_stall_cyc;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_acc = 0;
    beat_t beat_q[$];
    logic [1:0] rel_q[$];

    pp_qk_read_sequencer #(
        .INNER_BLK (IB),
        .ROW_TILES (RT),
        .COL_TILES (CT),
        .W_WIDTH   (WW),
        .N_WIDTH   (NW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_bank_full  (w_bank_full),
        .n_bank_full  (n_bank_full),
        .bank_release (bank_release),
        .rd_bank      (rd_bank),
        .w_rd_en      (w_rd_en),
        .w_rd_addr    (w_rd_addr),
        .n_rd_en      (n_rd_en),
        .n_rd_addr    (n_rd_addr),
        .w_rd_data    (w_rd_data),
        .n_rd_data    (n_rd_data),
        .mm_ready     (mm_ready),
        .mm_valid     (mm_valid),
        .mm_w_data    (mm_w_data),
        .mm_n_data    (mm_n_data),
        .mm_first     (mm_first),
        .mm_last      (mm_last),
        .seq_done     (seq_done)
`ifdef PP_SEQ_PERF_EN
        ,
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer read model: word tagged with bank and address, 1-cycle latency, held otherwise.
    initial begin
        logic          we;
        logic          ne;
        logic [AW-1:0] wa;
        logic [AN-1:0] na;
        logic          bk;
        w_rd_data = '0;
        n_rd_data = '0;
        forever begin
            @(posedge clk);
            we = w_rd_en; wa = w_rd_addr;
            ne = n_rd_en; na = n_rd_addr;
            bk = rd_bank;
            #1;
            if (we) w_rd_data = {16'hA000, 7'd0, bk, 8'(wa)};
            if (ne) n_rd_data = {16'hB000, 7'd0, bk, 8'(na)};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats for one bank; addresses listed by hand for the 2x2x2 geometry.
    task automatic push_bank(input logic b, input int count, input bit with_release);
        int w_seq[8];
        int n_seq[8];
        beat_t e;
        w_seq = '{0, 1, 0, 1, 2, 3, 2, 3};
        n_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < count; i++) begin
            e.w     = {16'hA000, 7'd0, b, 8'(w_seq[i])};
            e.n     = {16'hB000, 7'd0, b, 8'(n_seq[i])};
            e.first = ((i % 2) == 0);
            e.last  = ((i % 2) == 1);
            beat_q.push_back(e);
        end
        if (with_release) rel_q.push_back(b ? 2'b10 : 2'b01);
    endtask

    // One cycle step; the writer side refills nothing and drops full on release.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            if (bank_release[b]) begin
                w_bank_full[b] = 1'b0;
                n_bank_full[b] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!seq_done && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (!seq_done) begin
            n_fail++;
            $display("FAIL %s: no seq_done after %0d cycles, expected within %0d", name, n, budget);
        end
    endtask

    // Monitor: pops on every accepted beat / release, and checks stall stability.
    initial begin
        beat_t got;
        beat_t exp;
        beat_t held;
        logic [1:0] erel;
        bit stall_pending;
        stall_pending = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pending = 0;
            end else begin
                got = '{w: mm_w_data, n: mm_n_data, first: mm_first, last: mm_last};
                if (stall_pending) begin
                    n_checks++;
                    if (!mm_valid || got !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", mm_valid, got, held);
                    end
                end
                stall_pending = mm_valid && !mm_ready;
                held = got;
                if (mm_valid && mm_ready) begin
                    n_checks++;
                    beats_acc++;
                    if (beat_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_unexpected: got %h expected none", got);
                    end else begin
                        exp = beat_q.pop_front();
                        if (got !== exp) begin
                            n_fail++;
                            $display("FAIL beat: got %h expected %h", got, exp);
                        end
                    end
                end
                if (bank_release != 2'b00) begin
                    n_checks++;
                    if (rel_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL release_unexpected: got %b expected 00", bank_release);
                    end else begin
                        erel = rel_q.pop_front();
                        if (bank_release !== erel || seq_done !== 1'b1) begin
                            n_fail++;
                            $display("FAIL release: got %b done=%0b expected %b done=1",
                                     bank_release, seq_done, erel);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        int base;
`ifdef PP_SEQ_PERF_EN
        logic [31:0] busy0;
        logic [31:0] stall0;
`endif
        rst_n       = 1'b0;
        w_bank_full = 2'b00;
        n_bank_full = 2'b00;
        mm_ready    = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_mm_valid",  64'(mm_valid),     64'd0);
        chk("rst_w_rd_en",   64'(w_rd_en),      64'd0);
        chk("rst_n_rd_en",   64'(n_rd_en),      64'd0);
        chk("rst_rd_bank",   64'(rd_bank),      64'd0);
        chk("rst_release",   64'(bank_release), 64'd0);
        chk("rst_seq_done",  64'(seq_done),     64'd0);
        chk("rst_mm_first",  64'(mm_first),     64'd0);
        chk("rst_mm_last",   64'(mm_last),      64'd0);
        chk("rst_w_addr",    64'(w_rd_addr),    64'd0);
        chk("rst_n_addr",    64'(n_rd_addr),    64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Basic bank 0 stream, mm_ready held high
        push_bank(1'b0, 8, 1'b1);
        w_bank_full[0] = 1'b1;
        n_bank_full[0] = 1'b1;
        wait_done("basic_done", 40);
        tick();

        // Bank 1 with mm_ready 0,1,0,1... starting the cycle full is raised
        push_bank(1'b1, 8, 1'b1);
`ifdef PP_SEQ_PERF_EN
        busy0  = perf_busy_cyc;
        stall0 = perf_stall_cyc;
`endif
        w_bank_full[1] = 1'b1;
        n_bank_full[1] = 1'b1;
        base = beats_acc;
        for (int i = 0; i < 24; i++) begin
            mm_ready = (i % 2) == 1;
            tick();
        end
        mm_ready = 1'b1;
        chk("stall_beats", 64'(beats_acc - base), 64'd8);
        chk("stall_q_empty", 64'(beat_q.size()), 64'd0);
`ifdef PP_SEQ_PERF_EN
        chk("perf_stall", 64'(perf_stall_cyc - stall0), 64'd8);
        chk("perf_busy",  64'(perf_busy_cyc - busy0),   64'd18);
`endif

        // Back-to-back banks: bank 1 filled while bank 0 streams
        push_bank(1'b0, 8, 1'b1);
        w_bank_full[0] = 1'b1;
        n_bank_full[0] = 1'b1;
        repeat (3) tick();
        push_bank(1'b1, 8, 1'b1);
        w_bank_full[1] = 1'b1;
        n_bank_full[1] = 1'b1;
        wait_done("b2b_first_done", 40);
        cnt = 0;
        while (!w_rd_en && cnt < 6) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt > 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles expected <= 2", cnt);
        end
        chk("b2b_rd_bank", 64'(rd_bank), 64'd1);
        tick();
        wait_done("b2b_second_done", 40);
        tick();

        // Only the West half is full: nothing may be read
        w_bank_full[0] = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            cnt += int'(w_rd_en | n_rd_en);
        end
        chk("wonly_no_rd", 64'(cnt), 64'd0);
        push_bank(1'b0, 8, 1'b1);
        n_bank_full[0] = 1'b1;
        tick();
        chk("wonly_start_en",   64'(w_rd_en),   64'd1);
        chk("wonly_start_addr", 64'(w_rd_addr), 64'd0);
        wait_done("wonly_done", 40);
        tick();

        // Reset while beat 3 is being fetched from bank 1
        push_bank(1'b1, 3, 1'b0);
        w_bank_full[1] = 1'b1;
        n_bank_full[1] = 1'b1;
        base = beats_acc;
        cnt = 0;
        while (beats_acc < base + 3 && cnt < 30) begin
            tick();
            cnt++;
        end
        chk("mid_beats_before_rst", 64'(beats_acc - base), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mm_valid", 64'(mm_valid),     64'd0);
        chk("mid_rst_w_rd_en",  64'(w_rd_en),      64'd0);
        chk("mid_rst_release",  64'(bank_release), 64'd0);
        chk("mid_rst_seq_done", 64'(seq_done),     64'd0);
        chk("mid_rst_rd_bank",  64'(rd_bank),      64'd0);
        chk("mid_rst_mm_wdata", 64'(mm_w_data),    64'd0);
        chk("mid_rst_mm_first", 64'(mm_first),     64'd0);
        w_bank_full[1] = 1'b0;
        n_bank_full[1] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Restart after reset begins again at bank 0, address 0
        push_bank(1'b0, 8, 1'b1);
        w_bank_full[0] = 1'b1;
        n_bank_full[0] = 1'b1;
        wait_done("restart_done", 40);
        repeat (4) tick();

        chk("end_beat_q_empty", 64'(beat_q.size()), 64'd0);
        chk("end_rel_q_empty",  64'(rel_q.size()),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
